// File: rtl/axi_wr_slave_mo.sv
// rtl/axi_wr_slave_mo.sv - AXI4 write slave with queued bursts and a registered sink stage
// Beats are address-stepped per burst type and handed to the sink; B responses return in AW order.
module axi_wr_slave_mo #(
  parameter int ID_W     = 8,
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 64,
  parameter int REGION_W = 2,
  parameter int AW_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [7:0]          AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic [3:0]          AWREGION,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  output logic                wr_vld,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W/8-1:0] wr_strb,
  output logic [REGION_W-1:0] wr_region,
  output logic                wr_last,
  input  logic                wr_ready,
  input  logic                wr_err
);
  localparam int NB = DATA_W / 8;
  localparam int PW = $clog2(AW_DEPTH);
  localparam logic [2:0] MAX_SIZE = 3'($clog2(NB));

  typedef struct packed {
    logic [ID_W-1:0]     id;
    logic [ADDR_W-1:0]   addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
    logic [REGION_W-1:0] region;
  } aw_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_t;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t              state_q, state_d;
  aw_t                 aw_mem_q [AW_DEPTH];
  aw_t                 aw_mem_d [AW_DEPTH];
  b_t                  b_mem_q [AW_DEPTH];
  b_t                  b_mem_d [AW_DEPTH];
  logic [PW-1:0]       aw_wp_q, aw_wp_d, aw_rp_q, aw_rp_d, b_wp_q, b_wp_d, b_rp_q, b_rp_d;
  logic [PW:0]         aw_cnt_q, aw_cnt_d, b_cnt_q, b_cnt_d, credit_q, credit_d;
  logic [ID_W-1:0]     id_q, id_d, wr_id_q, wr_id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic [7:0]          len_q, len_d, beat_cnt_q, beat_cnt_d;
  logic [2:0]          size_q, size_d;
  logic [1:0]          burst_q, burst_d;
  logic [REGION_W-1:0] region_q, region_d, wr_region_q, wr_region_d;
  logic                err_q, err_d, wr_berr_q, wr_berr_d;
  logic                wr_vld_q, wr_vld_d, wr_last_q, wr_last_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [NB-1:0]       wr_strb_q, wr_strb_d;

  aw_t                 aw_head;
  b_t                  b_head;
  logic                aw_full, aw_push, aw_pop, w_hs, sink_hs, b_push, b_pop;
  logic                mismatch, err_now, aw_err, wrap_len_ok, region_unused;
  logic [ADDR_W-1:0]   head_sz, sz, incr_addr, wrap_mask, wrap_addr, next_addr;

  // Upper AWREGION bits are intentionally dropped; only REGION_W bits reach the sink.
  assign region_unused = ^AWREGION;

  assign aw_head = aw_mem_q[aw_rp_q];
  assign b_head  = b_mem_q[b_rp_q];
  assign aw_full = aw_cnt_q == (PW+1)'(AW_DEPTH);
  assign AWREADY = ~aw_full & ~rst;
  assign aw_push = AWVALID & AWREADY;
  assign aw_pop  = (state_q == IDLE) & (aw_cnt_q != '0) & (credit_q != '0);
  assign WREADY  = (state_q == ACTIVE) & (~wr_vld_q | wr_ready) & ~rst;
  assign w_hs    = WVALID & WREADY;
  assign sink_hs = wr_vld_q & wr_ready;
  assign b_push  = sink_hs & wr_last_q;
  assign BVALID  = b_cnt_q != '0;
  assign b_pop   = BVALID & BREADY;
  assign BID     = BVALID ? b_head.id : '0;
  assign BRESP   = BVALID ? b_head.resp : 2'b00;

  assign wr_vld    = wr_vld_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_strb   = wr_strb_q;
  assign wr_region = wr_region_q;
  assign wr_last   = wr_last_q;

  assign head_sz     = ADDR_W'(1) << aw_head.size;
  assign wrap_len_ok = aw_head.len inside {8'd1, 8'd3, 8'd7, 8'd15};
  assign aw_err = (aw_head.burst == 2'b11) | (aw_head.size > MAX_SIZE) |
                  ((aw_head.burst == 2'b10) & ~wrap_len_ok) |
                  ((aw_head.burst == 2'b10) & ((aw_head.addr & (head_sz - ADDR_W'(1))) != '0));

  // WRAP keeps the bits above the window and steps only inside it.
  assign sz        = ADDR_W'(1) << size_q;
  assign incr_addr = (addr_q & ~(sz - ADDR_W'(1))) + sz;
  assign wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
  assign wrap_addr = (addr_q & ~wrap_mask) | ((addr_q + sz) & wrap_mask);
  assign next_addr = (burst_q == 2'b00) ? addr_q : (burst_q == 2'b10) ? wrap_addr : incr_addr;

  // A sink error on a non-last beat belongs to the burst still being received.
  assign mismatch = WLAST != (beat_cnt_q == 8'd0);
  assign err_now  = err_q | (sink_hs & ~wr_last_q & wr_err) | (w_hs & mismatch);

  always_comb begin
    state_d     = state_q;
    aw_mem_d    = aw_mem_q;
    b_mem_d     = b_mem_q;
    aw_wp_d     = aw_wp_q;
    aw_rp_d     = aw_rp_q;
    aw_cnt_d    = aw_cnt_q;
    b_wp_d      = b_wp_q;
    b_rp_d      = b_rp_q;
    b_cnt_d     = b_cnt_q;
    credit_d    = credit_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    region_d    = region_q;
    beat_cnt_d  = beat_cnt_q;
    err_d       = err_q;
    wr_vld_d    = wr_vld_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_strb_d   = wr_strb_q;
    wr_region_d = wr_region_q;
    wr_last_d   = wr_last_q;
    wr_id_d     = wr_id_q;
    wr_berr_d   = wr_berr_q;

    if (aw_push) begin
      aw_mem_d[aw_wp_q] = '{AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWREGION[REGION_W-1:0]};
      aw_wp_d = aw_wp_q + PW'(1);
    end
    if (aw_pop) aw_rp_d = aw_rp_q + PW'(1);
    case ({aw_push, aw_pop})
      2'b10:   aw_cnt_d = aw_cnt_q + (PW+1)'(1);
      2'b01:   aw_cnt_d = aw_cnt_q - (PW+1)'(1);
      default: aw_cnt_d = aw_cnt_q;
    endcase

    case (state_q)
      IDLE: begin
        if (aw_pop) begin
          state_d    = ACTIVE;
          id_d       = aw_head.id;
          addr_d     = aw_head.addr;
          len_d      = aw_head.len;
          size_d     = aw_head.size;
          burst_d    = (aw_head.burst == 2'b11) ? 2'b01 : aw_head.burst;
          region_d   = aw_head.region;
          beat_cnt_d = aw_head.len;
          err_d      = aw_err;
        end
      end
      ACTIVE: begin
        err_d = err_now;
        if (w_hs) begin
          addr_d = next_addr;
          if (beat_cnt_q == 8'd0) state_d = IDLE;
          else beat_cnt_d = beat_cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (w_hs) begin
      wr_vld_d    = 1'b1;
      wr_addr_d   = addr_q;
      wr_data_d   = WDATA;
      wr_strb_d   = err_now ? '0 : WSTRB;
      wr_region_d = region_q;
      wr_last_d   = beat_cnt_q == 8'd0;
      wr_id_d     = id_q;
      wr_berr_d   = err_now;
    end else if (sink_hs) begin
      wr_vld_d = 1'b0;
    end

    if (b_push) begin
      b_mem_d[b_wp_q] = '{wr_id_q, (wr_berr_q | wr_err) ? 2'b10 : 2'b00};
      b_wp_d = b_wp_q + PW'(1);
    end
    if (b_pop) b_rp_d = b_rp_q + PW'(1);
    case ({b_push, b_pop})
      2'b10:   b_cnt_d = b_cnt_q + (PW+1)'(1);
      2'b01:   b_cnt_d = b_cnt_q - (PW+1)'(1);
      default: b_cnt_d = b_cnt_q;
    endcase

    case ({aw_pop, b_pop})
      2'b10:   credit_d = credit_q - (PW+1)'(1);
      2'b01:   credit_d = credit_q + (PW+1)'(1);
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk) begin
    aw_mem_q    <= aw_mem_d;
    b_mem_q     <= b_mem_d;
    id_q        <= id_d;
    addr_q      <= addr_d;
    len_q       <= len_d;
    size_q      <= size_d;
    burst_q     <= burst_d;
    region_q    <= region_d;
    beat_cnt_q  <= beat_cnt_d;
    err_q       <= err_d;
    wr_addr_q   <= wr_addr_d;
    wr_data_q   <= wr_data_d;
    wr_strb_q   <= wr_strb_d;
    wr_region_q <= wr_region_d;
    wr_id_q     <= wr_id_d;
    wr_berr_q   <= wr_berr_d;
    if (rst) begin
      state_q   <= IDLE;
      aw_wp_q   <= '0;
      aw_rp_q   <= '0;
      aw_cnt_q  <= '0;
      b_wp_q    <= '0;
      b_rp_q    <= '0;
      b_cnt_q   <= '0;
      credit_q  <= (PW+1)'(AW_DEPTH);
      wr_vld_q  <= 1'b0;
      wr_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_wp_q   <= aw_wp_d;
      aw_rp_q   <= aw_rp_d;
      aw_cnt_q  <= aw_cnt_d;
      b_wp_q    <= b_wp_d;
      b_rp_q    <= b_rp_d;
      b_cnt_q   <= b_cnt_d;
      credit_q  <= credit_d;
      wr_vld_q  <= wr_vld_d;
      wr_last_q <= wr_last_d;
    end
  end
endmodule

// File: tb/tb_axi_wr_slave_mo.sv
// tb/tb_axi_wr_slave_mo.sv - scoreboard bench for the AXI4 multi-outstanding write slave
// Expected sink beats and B responses are queued at stimulus time and popped by a negedge monitor.
module tb_axi_wr_slave_mo;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  AWID;
  logic [10:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic [3:0]  AWREGION;
  logic        AWVALID;
  logic        AWREADY;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [7:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic        wr_vld;
  logic [10:0] wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_strb;
  logic [1:0]  wr_region;
  logic        wr_last;
  logic        wr_ready;
  logic        wr_err;

  typedef struct {
    logic [10:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic [1:0]  region;
    bit          chk_addr;
  } beat_t;

  typedef struct {
    logic [7:0] id;
    logic [1:0] resp;
  } bresp_t;

  beat_t  exp_beats[$];
  bresp_t exp_bs[$];
  beat_t  mon_beat;
  bresp_t mon_b;
  int     checks = 0;
  int     errors = 0;

  always #5 clk = ~clk;

  axi_wr_slave_mo dut (
    .clk(clk), .rst(rst),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWREGION(AWREGION), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .wr_vld(wr_vld), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_region(wr_region), .wr_last(wr_last), .wr_ready(wr_ready), .wr_err(wr_err)
  );

  function automatic logic [63:0] wdata(input logic [7:0] id, input int k);
    return 64'hA500_0000_0000_0000 | (64'(id) << 32) | 64'(k);
  endfunction

  function automatic logic [7:0] wstrb(input int k);
    return 8'hF0 | 8'(k);
  endfunction

  function automatic logic [10:0] exp_addr(input int start, input int k, input int len,
                                           input int size, input int btype);
    int sz, win, base;
    sz = 1 << size;
    if (btype == 0) return 11'(start);
    if (btype == 2) begin
      win  = (len + 1) * sz;
      base = start - (start % win);
      return 11'(base + ((start - base + k * sz) % win));
    end
    if (k == 0) return 11'(start);
    return 11'((((start / sz) * sz) + k * sz) % 2048);
  endfunction

  always @(negedge clk) begin
    if (!rst && wr_vld && wr_ready) begin
      checks++;
      if (exp_beats.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected got addr=%h data=%h required none", wr_addr, wr_data);
      end else begin
        mon_beat = exp_beats.pop_front();
        if ((mon_beat.chk_addr && wr_addr !== mon_beat.addr) || wr_data !== mon_beat.data ||
            wr_strb !== mon_beat.strb || wr_last !== mon_beat.last || wr_region !== mon_beat.region) begin
          errors++;
          $display("FAIL beat got addr=%h data=%h strb=%h last=%b region=%h required addr=%h data=%h strb=%h last=%b region=%h",
                   wr_addr, wr_data, wr_strb, wr_last, wr_region,
                   mon_beat.addr, mon_beat.data, mon_beat.strb, mon_beat.last, mon_beat.region);
        end
      end
    end
    if (!rst && BVALID && BREADY) begin
      checks++;
      if (exp_bs.size() == 0) begin
        errors++;
        $display("FAIL bresp_unexpected got id=%h resp=%b required none", BID, BRESP);
      end else begin
        mon_b = exp_bs.pop_front();
        if (BID !== mon_b.id || BRESP !== mon_b.resp) begin
          errors++;
          $display("FAIL bresp got id=%h resp=%b required id=%h resp=%b", BID, BRESP, mon_b.id, mon_b.resp);
        end
      end
    end
  end

  task automatic send_aw(input logic [7:0] id, input int addr, input int len, input int size,
                         input int btype, input logic [1:0] region);
    int n = 0;
    AWID = id; AWADDR = 11'(addr); AWLEN = 8'(len); AWSIZE = 3'(size);
    AWBURST = 2'(btype); AWREGION = {2'b10, region}; AWVALID = 1'b1;
    do begin @(negedge clk); n++; end while (!AWREADY && n < 200);
    if (!AWREADY) begin
      checks++; errors++;
      $display("FAIL aw_timeout got AWREADY=0 required 1 id=%h", id);
    end
    @(posedge clk); #1;
    AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
    int n = 0;
    WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
    do begin @(negedge clk); n++; end while (!WREADY && n < 200);
    if (!WREADY) begin
      checks++; errors++;
      $display("FAIL w_timeout got WREADY=0 required 1 data=%h", data);
    end
    @(posedge clk); #1;
    WVALID = 1'b0;
  endtask

  task automatic expect_burst(input logic [7:0] id, input int addr, input int len, input int size,
                              input int btype, input logic [1:0] region, input int err_from,
                              input bit chk_addr);
    beat_t  e;
    bresp_t b;
    for (int k = 0; k <= len; k++) begin
      e.addr = exp_addr(addr, k, len, size, btype);
      e.data = wdata(id, k);
      e.strb = (k >= err_from) ? 8'h00 : wstrb(k);
      e.last = (k == len);
      e.region = region;
      e.chk_addr = chk_addr;
      exp_beats.push_back(e);
    end
    b.id = id;
    b.resp = (err_from <= len) ? 2'b10 : 2'b00;
    exp_bs.push_back(b);
  endtask

  task automatic burst(input logic [7:0] id, input int addr, input int len, input int size,
                       input int btype, input logic [1:0] region, input int err_from,
                       input int bad_last, input bit chk_addr);
    expect_burst(id, addr, len, size, btype, region, err_from, chk_addr);
    send_aw(id, addr, len, size, btype, region);
    for (int k = 0; k <= len; k++)
      send_w(wdata(id, k), wstrb(k), (k == len) ^ (k == bad_last));
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_beats.size() != 0 || exp_bs.size() != 0) && n < 300) begin
      @(negedge clk); n++;
    end
    checks++;
    if (exp_beats.size() != 0 || exp_bs.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got beats=%0d bresps=%0d pending required 0", name, exp_beats.size(), exp_bs.size());
      exp_beats.delete();
      exp_bs.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string name);
    checks += 6;
    if (AWREADY !== 1'b0) begin errors++; $display("FAIL %s_awready got %b required 0", name, AWREADY); end
    if (WREADY !== 1'b0) begin errors++; $display("FAIL %s_wready got %b required 0", name, WREADY); end
    if (BVALID !== 1'b0) begin errors++; $display("FAIL %s_bvalid got %b required 0", name, BVALID); end
    if (wr_vld !== 1'b0) begin errors++; $display("FAIL %s_wr_vld got %b required 0", name, wr_vld); end
    if (BRESP !== 2'b00) begin errors++; $display("FAIL %s_bresp got %b required 00", name, BRESP); end
    if (wr_last !== 1'b0) begin errors++; $display("FAIL %s_wr_last got %b required 0", name, wr_last); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    AWVALID = 1'b0; WVALID = 1'b0; WLAST = 1'b0; WDATA = '0; WSTRB = '0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWREGION = '0;
    BREADY = 1'b1; wr_ready = 1'b1; wr_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (AWREADY !== 1'b1) begin errors++; $display("FAIL reset_release_awready got %b required 1", AWREADY); end
    @(posedge clk); #1;
  endtask

  task automatic test_incr;
    burst(8'h03, 'h010, 3, 3, 1, 2'd1, 99, -1, 1'b1);
    burst(8'h0A, 'h013, 2, 1, 1, 2'd2, 99, -1, 1'b1);
    burst(8'h0B, 'h7F8, 1, 3, 1, 2'd3, 99, -1, 1'b1);
    wait_drain("incr");
  endtask

  task automatic test_wrap;
    burst(8'h04, 'h018, 3, 3, 2, 2'd0, 99, -1, 1'b1);
    burst(8'h14, 'h018, 2, 3, 2, 2'd0, 0, -1, 1'b0);
    burst(8'h24, 'h014, 3, 3, 2, 2'd1, 0, -1, 1'b0);
    wait_drain("wrap");
  endtask

  task automatic test_fixed_and_errors;
    burst(8'h05, 'h005, 1, 1, 0, 2'd2, 99, -1, 1'b1);
    burst(8'h15, 'h020, 1, 3, 1, 2'd2, 0, 0, 1'b1);
    burst(8'h25, 'h030, 1, 4, 1, 2'd3, 0, -1, 1'b0);
    burst(8'h35, 'h040, 1, 3, 3, 2'd1, 0, -1, 1'b1);
    wait_drain("fixed_err");
  endtask

  task automatic test_back_to_back;
    BREADY = 1'b0;
    for (int i = 0; i < 5; i++) expect_burst(8'(i), i * 8, 0, 3, 1, 2'd1, 99, 1'b1);
    for (int i = 0; i < 5; i++) send_aw(8'(i), i * 8, 0, 3, 1, 2'd1);
    @(negedge clk);
    checks++;
    if (AWREADY !== 1'b0) begin errors++; $display("FAIL b2b_aw_full got AWREADY=%b required 0", AWREADY); end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send_w(wdata(8'(i), 0), wstrb(0), 1'b1);
    WDATA = wdata(8'd4, 0); WSTRB = wstrb(0); WLAST = 1'b1; WVALID = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (WREADY !== 1'b0) begin errors++; $display("FAIL b2b_credit_stall got WREADY=%b required 0 cycle=%0d", WREADY, c); end
    end
    checks += 2;
    if (BVALID !== 1'b1) begin errors++; $display("FAIL b2b_bvalid_held got %b required 1", BVALID); end
    if (BID !== 8'd0) begin errors++; $display("FAIL b2b_bid_head got %h required 00", BID); end
    @(posedge clk); #1;
    BREADY = 1'b1;
    send_w(wdata(8'd4, 0), wstrb(0), 1'b1);
    wait_drain("b2b");
  endtask

  task automatic test_sink_stall;
    wr_ready = 1'b0;
    fork
      burst(8'h06, 'h040, 3, 3, 1, 2'd1, 2, -1, 1'b1);
      begin
        int n;
        for (int k = 0; k < 4; k++) begin
          n = 0;
          do begin @(negedge clk); n++; end while (!wr_vld && n < 200);
          if (!wr_vld) begin
            checks++; errors++;
            $display("FAIL stall_vld_timeout got wr_vld=0 required 1 beat=%0d", k);
          end
          if (k == 1) begin
            for (int c = 0; c < 3; c++) begin
              @(posedge clk); @(negedge clk);
              checks++;
              if (WREADY !== 1'b0 || wr_vld !== 1'b1 || wr_addr !== 11'h048 || wr_data !== wdata(8'h06, 1)) begin
                errors++;
                $display("FAIL stall_hold got wready=%b vld=%b addr=%h data=%h required 0 1 048 %h",
                         WREADY, wr_vld, wr_addr, wr_data, wdata(8'h06, 1));
              end
            end
          end
          @(posedge clk); #1;
          wr_ready = 1'b1; wr_err = (k == 1);
          @(posedge clk); #1;
          wr_ready = 1'b0; wr_err = 1'b0;
        end
        wr_ready = 1'b1;
      end
    join
    wait_drain("stall");
    burst(8'h16, 'h100, 1, 3, 1, 2'd0, 99, -1, 1'b1);
    wait_drain("stall_next");
  endtask

  task automatic test_reset_mid_burst;
    wr_ready = 1'b0;
    send_aw(8'h07, 'h080, 3, 3, 1, 2'd1);
    send_w(wdata(8'h07, 0), wstrb(0), 1'b0);
    WDATA = wdata(8'h07, 1); WSTRB = wstrb(1); WLAST = 1'b0; WVALID = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; WVALID = 1'b0;
    @(posedge clk); @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0; wr_ready = 1'b1;
    burst(8'h17, 'h0C0, 2, 2, 1, 2'd2, 99, -1, 1'b1);
    wait_drain("after_rst");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_fixed_and_errors();
    test_back_to_back();
    test_sink_stall();
    test_reset_mid_burst();
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
